// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog -- programmable integer clock divider
//
// Produces a registered, glitch-free divided square wave whose period is
// E = max(cur_n, 1) input clock cycles. The output is high for ceil(E/2)
// cycles and low for floor(E/2) cycles. A new ratio is captured by the load
// strobe. It only takes effect at a period boundary, so a running period is
// never cut short or stretched.
//
// Parameters
//   WIDTH      width of the divide-ratio path and period counter
//   RESET_DIV  divide ratio in effect after reset (1 .. 2^WIDTH-1)
//
// Ports
//   clk        input   single clock, rising edge
//   reset      input   asynchronous active-low reset
//   en         input   run enable (level)
//   div_ratio  input   requested divide ratio N (0 is treated as 1)
//   load       input   one-cycle strobe capturing div_ratio as pending ratio
//   clk_out    output  divided square wave (flop output)
//   tick       output  one-cycle pulse on the first cycle of each period
//   ratio_ack  output  one-cycle pulse when a pending ratio becomes active
// -----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             ratio_ack
);

    localparam logic [WIDTH-1:0] RESET_N = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    // Effective ratio: a programmed 0 behaves like 1.
    function automatic logic [WIDTH-1:0] eff_ratio(input logic [WIDTH-1:0] n);
        return (n == ZERO_W) ? ONE_W : n;
    endfunction

    // Number of high cycles, ceil(e/2); one extra bit so e = 2^WIDTH-1 cannot wrap.
    function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] e);
        return ({1'b0, e} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    endfunction

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cur_n;
    logic [WIDTH-1:0] r_pend_n;
    logic             r_pend_v;
    logic             r_run;       // previous edge sampled en high
    logic             r_clk_out;
    logic             r_tick;
    logic             r_ratio_ack;

    logic [WIDTH-1:0] w_e;
    logic             w_last;
    logic [WIDTH-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_cur_nx;
    logic [WIDTH-1:0] w_pend_n_nx;
    logic             w_pend_v_nx;
    logic             w_apply;
    logic             w_clk_nx;
    logic             w_tick_nx;

    // Next-state: counter advance, period boundaries and ratio hand-over.
    always_comb begin
        w_e         = eff_ratio(r_cur_n);
        w_last      = (r_cnt == (w_e - ONE_W));
        w_cnt_nx    = ZERO_W;
        w_cur_nx    = r_cur_n;
        w_pend_n_nx = load ? div_ratio : r_pend_n;
        w_pend_v_nx = r_pend_v;
        w_apply     = 1'b0;
        if (en) begin
            if (!r_run || w_last) begin
                // Period boundary (first enabled edge or wrap): a load seen on
                // this same edge wins over an older pending value.
                w_cnt_nx = ZERO_W;
                if (load) begin
                    w_cur_nx    = div_ratio;
                    w_pend_v_nx = 1'b0;
                    w_apply     = 1'b1;
                end else if (r_pend_v) begin
                    w_cur_nx    = r_pend_n;
                    w_pend_v_nx = 1'b0;
                    w_apply     = 1'b1;
                end else begin
                    w_cur_nx    = r_cur_n;
                end
            end else begin
                w_cnt_nx = r_cnt + ONE_W;
                if (load) begin
                    w_pend_v_nx = 1'b1;
                end else begin
                    w_pend_v_nx = r_pend_v;
                end
            end
        end else begin
            // Idle: a pending ratio applies on the edge after it was loaded;
            // a fresh load re-arms the pending slot instead.
            w_cnt_nx = ZERO_W;
            if (load) begin
                w_pend_v_nx = 1'b1;
            end else if (r_pend_v) begin
                w_cur_nx    = r_pend_n;
                w_pend_v_nx = 1'b0;
                w_apply     = 1'b1;
            end else begin
                w_pend_v_nx = 1'b0;
            end
        end
        // Outputs are derived from the next count and next ratio so that they
        // land in the same flop stage as the counter.
        w_clk_nx  = en && ({1'b0, w_cnt_nx} < high_len(eff_ratio(w_cur_nx)));
        w_tick_nx = en && (w_cnt_nx == ZERO_W);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= ZERO_W;
            r_cur_n     <= RESET_N;
            r_pend_n    <= ZERO_W;
            r_pend_v    <= 1'b0;
            r_run       <= 1'b0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_ratio_ack <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nx;
            r_cur_n     <= w_cur_nx;
            r_pend_n    <= w_pend_n_nx;
            r_pend_v    <= w_pend_v_nx;
            r_run       <= en;
            r_clk_out   <= w_clk_nx;
            r_tick      <= w_tick_nx;
            r_ratio_ack <= w_apply;
        end
    end

    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign ratio_ack = r_ratio_ack;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog -- directed self-checking bench for clk_div_prog
// (WIDTH = 8, RESET_DIV = 2). Expected clk_out/tick/ratio_ack values are
// hand-derived per edge; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] div_ratio;
    logic       load;
    logic       clk_out;
    logic       tick;
    logic       ratio_ack;

    int n_asserts;
    int n_fail;

    clk_div_prog #(
        .WIDTH     (8),
        .RESET_DIV (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_ratio (div_ratio),
        .load      (load),
        .clk_out   (clk_out),
        .tick      (tick),
        .ratio_ack (ratio_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all three outputs against expectations right now.
    task automatic chk(input string tag, input logic ec, input logic et, input logic ea);
        n_asserts++;
        assert (clk_out === ec) else begin
            n_fail++;
            $error("FAIL %s clk_out got %b exp %b", tag, clk_out, ec);
        end
        n_asserts++;
        assert (tick === et) else begin
            n_fail++;
            $error("FAIL %s tick got %b exp %b", tag, tick, et);
        end
        n_asserts++;
        assert (ratio_ack === ea) else begin
            n_fail++;
            $error("FAIL %s ratio_ack got %b exp %b", tag, ratio_ack, ea);
        end
    endtask

    // Advance one clock edge, then check.
    task automatic step(input string tag, input logic ec, input logic et, input logic ea);
        @(posedge clk);
        #1;
        chk(tag, ec, et, ea);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        div_ratio = 8'd0;
        #12;
        chk("reset_state", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        en    = 1'b1;

        // Default ratio 2 after reset: toggle every cycle, tick on highs
        step("rd2_e1", 1'b1, 1'b1, 1'b0);
        step("rd2_e2", 1'b0, 1'b0, 1'b0);
        step("rd2_e3", 1'b1, 1'b1, 1'b0);
        step("rd2_e4", 1'b0, 1'b0, 1'b0);

        // Load 4 on a wrap edge: applied immediately
        load = 1'b1; div_ratio = 8'd4;
        step("n4_wrapload", 1'b1, 1'b1, 1'b1);
        load = 1'b0;
        step("n4_c1", 1'b1, 1'b0, 1'b0);
        step("n4_c2", 1'b0, 1'b0, 1'b0);
        step("n4_c3", 1'b0, 1'b0, 1'b0);
        step("n4_c0", 1'b1, 1'b1, 1'b0);

        // Load 5 mid-period of N=4: current period completes first
        load = 1'b1; div_ratio = 8'd5;
        step("n5_pend_c1", 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        step("n5_pend_c2", 1'b0, 1'b0, 1'b0);
        step("n5_pend_c3", 1'b0, 1'b0, 1'b0);
        step("n5_c0_ack", 1'b1, 1'b1, 1'b1);
        step("n5_c1", 1'b1, 1'b0, 1'b0);
        step("n5_c2", 1'b1, 1'b0, 1'b0);
        step("n5_c3", 1'b0, 1'b0, 1'b0);
        step("n5_c4", 1'b0, 1'b0, 1'b0);
        step("n5_c0", 1'b1, 1'b1, 1'b0);

        // Ratio 1, then ratio 0: constant high, tick every cycle
        load = 1'b1; div_ratio = 8'd1;
        step("n1_pend_c1", 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        step("n1_pend_c2", 1'b1, 1'b0, 1'b0);
        step("n1_pend_c3", 1'b0, 1'b0, 1'b0);
        step("n1_pend_c4", 1'b0, 1'b0, 1'b0);
        step("n1_ack", 1'b1, 1'b1, 1'b1);
        step("n1_a", 1'b1, 1'b1, 1'b0);
        step("n1_b", 1'b1, 1'b1, 1'b0);
        load = 1'b1; div_ratio = 8'd0;
        step("n0_ack", 1'b1, 1'b1, 1'b1);
        load = 1'b0;
        step("n0_a", 1'b1, 1'b1, 1'b0);
        step("n0_b", 1'b1, 1'b1, 1'b0);

        // N=8, then two loads (6, 3) in one period: single ack, N=3 wins
        load = 1'b1; div_ratio = 8'd8;
        step("n8_ack", 1'b1, 1'b1, 1'b1);
        load = 1'b0;
        step("n8_c1", 1'b1, 1'b0, 1'b0);
        load = 1'b1; div_ratio = 8'd6;
        step("n8_c2_ld6", 1'b1, 1'b0, 1'b0);
        div_ratio = 8'd3;
        step("n8_c3_ld3", 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        step("n8_c4", 1'b0, 1'b0, 1'b0);
        step("n8_c5", 1'b0, 1'b0, 1'b0);
        step("n8_c6", 1'b0, 1'b0, 1'b0);
        step("n8_c7", 1'b0, 1'b0, 1'b0);
        step("n3_c0_ack", 1'b1, 1'b1, 1'b1);
        step("n3_c1", 1'b1, 1'b0, 1'b0);
        step("n3_c2", 1'b0, 1'b0, 1'b0);
        step("n3_c0_noack", 1'b1, 1'b1, 1'b0);
        step("n3_c1b", 1'b1, 1'b0, 1'b0);
        step("n3_c2b", 1'b0, 1'b0, 1'b0);
        step("n3_c0c", 1'b1, 1'b1, 1'b0);

        // N=6, disable at cnt=2 for 4 cycles, then re-enable
        load = 1'b1; div_ratio = 8'd6;
        step("n6_pend_c1", 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        step("n6_pend_c2", 1'b0, 1'b0, 1'b0);
        step("n6_c0_ack", 1'b1, 1'b1, 1'b1);
        step("n6_c1", 1'b1, 1'b0, 1'b0);
        step("n6_c2", 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step("dis_1", 1'b0, 1'b0, 1'b0);
        step("dis_2", 1'b0, 1'b0, 1'b0);
        step("dis_3", 1'b0, 1'b0, 1'b0);
        step("dis_4", 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        step("reen_c0", 1'b1, 1'b1, 1'b0);
        step("reen_c1", 1'b1, 1'b0, 1'b0);
        step("reen_c2", 1'b1, 1'b0, 1'b0);
        step("reen_c3", 1'b0, 1'b0, 1'b0);

        // Idle load of 4: applied on the edge after the load edge
        en = 1'b0;
        step("idle_a", 1'b0, 1'b0, 1'b0);
        load = 1'b1; div_ratio = 8'd4;
        step("idle_load", 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        step("idle_ack", 1'b0, 1'b0, 1'b1);
        step("idle_b", 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        step("i4_c0", 1'b1, 1'b1, 1'b0);
        step("i4_c1", 1'b1, 1'b0, 1'b0);
        step("i4_c2", 1'b0, 1'b0, 1'b0);
        step("i4_c3", 1'b0, 1'b0, 1'b0);
        step("i4_c0b", 1'b1, 1'b1, 1'b0);

        // Reset mid-period with load 7 pending
        load = 1'b1; div_ratio = 8'd7;
        step("rst_pend_c1", 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", 1'b0, 1'b0, 1'b0);
        step("rst_held", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step("post_rst_e1", 1'b1, 1'b1, 1'b0);
        step("post_rst_e2", 1'b0, 1'b0, 1'b0);
        step("post_rst_e3", 1'b1, 1'b1, 1'b0);
        step("post_rst_e4", 1'b0, 1'b0, 1'b0);

        // Maximum ratio 255: 128 high cycles, 127 low, no counter overflow
        load = 1'b1; div_ratio = 8'd255;
        step("n255_ack", 1'b1, 1'b1, 1'b1);
        load = 1'b0;
        for (int i = 1; i < 255; i++) begin
            step($sformatf("n255_c%0d", i), (i < 128) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        step("n255_wrap", 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
